// File: rtl/uart_tx_packetizer_pkg.sv
// Shared state encodings and constants for the UART frame packetizer and its byte issuer.
package uart_tx_packetizer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_COUNT,
        ST_FETCH,
        ST_DATA,
        ST_CHECKSUM
    } main_state_t;

    typedef enum logic [1:0] {
        IS_IDLE,
        IS_ISSUE,
        IS_WAIT_HI,
        IS_WAIT_LO
    } issue_state_t;

    localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;
    localparam int         CHECKSUM_WIDTH      = 8;

endpackage

// File: rtl/uart_tx_packetizer_if.sv
// Word-stream and UART-core signals of the packetizer; master is the packetizer side.
interface uart_tx_packetizer_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] word_in;
    logic                  word_valid;
    logic                  word_ready;
    logic [7:0]            tx_data;
    logic                  tx_start;
    logic                  tx_busy;
    logic                  frame_active;
    logic                  timeout_err;

    modport master (
        input  word_in, word_valid, tx_busy,
        output word_ready, tx_data, tx_start, frame_active, timeout_err
    );

    modport slave (
        output word_in, word_valid, tx_busy,
        input  word_ready, tx_data, tx_start, frame_active, timeout_err
    );
endinterface

// File: rtl/uart_byte_issuer.sv
// Hands one byte to uart_tx_core: start pulse, wait for busy to rise (with timeout), then fall.
module uart_byte_issuer
    import uart_tx_packetizer_pkg::*;
#(
    parameter int ACCEPT_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send_req,
    input  logic [7:0] send_byte,
    output logic       send_done,
    output logic       send_timeout,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy
);

    localparam int               CNT_W    = $clog2(ACCEPT_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEPT_TIMEOUT - 1);

    issue_state_t     state;
    issue_state_t     state_next;
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IS_IDLE;
            tx_data  <= 8'h00;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == IS_IDLE && send_req) begin
                tx_data <= send_byte;
            end
            if (state == IS_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == IS_WAIT_HI) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next   = state;
        send_done    = 1'b0;
        send_timeout = 1'b0;
        case (state)
            IS_IDLE: begin
                if (send_req) begin
                    state_next = IS_ISSUE;
                end
            end
            IS_ISSUE: begin
                state_next = IS_WAIT_HI;
            end
            IS_WAIT_HI: begin
                if (tx_busy) begin
                    state_next = IS_WAIT_LO;
                end else if (wait_cnt == CNT_LAST) begin
                    send_timeout = 1'b1;
                    state_next   = IS_IDLE;
                end
            end
            IS_WAIT_LO: begin
                if (!tx_busy) begin
                    send_done  = 1'b1;
                    state_next = IS_IDLE;
                end
            end
            default: begin
                state_next = IS_IDLE;
            end
        endcase
    end

    // Gated so a start pulse can never escape in a cycle where reset is asserted.
    assign tx_start = (state == IS_ISSUE) && !reset;

endmodule

// File: rtl/uart_tx_packetizer.sv
// Frames result words as header, count, MSB-first data bytes and an 8-bit checksum for uart_tx_core.
module uart_tx_packetizer
    import uart_tx_packetizer_pkg::*;
#(
    parameter int         WORD_WIDTH     = 16,
    parameter int         FRAME_WORDS    = 10,
    parameter logic [7:0] HEADER_BYTE    = DEFAULT_HEADER_BYTE,
    parameter int         ACCEPT_TIMEOUT = 32
) (
    input logic                  clk,
    input logic                  reset,
    uart_tx_packetizer_if.master bus
);

    localparam int         BYTES_PER_WORD = WORD_WIDTH / 8;
    localparam logic [1:0] LAST_BYTE      = 2'(BYTES_PER_WORD - 1);
    localparam logic [7:0] FRAME_COUNT    = 8'(FRAME_WORDS);

    main_state_t               state;
    main_state_t               state_next;
    logic [WORD_WIDTH-1:0]     word_reg;
    logic [1:0]                byte_cnt;
    logic [7:0]                words_sent;
    logic [CHECKSUM_WIDTH-1:0] checksum;
    logic                      timeout_err;
    logic                      transfer;
    logic                      send_req;
    logic [7:0]                send_byte;
    logic                      send_done;
    logic                      send_timeout;
    logic [7:0]                tx_data;
    logic                      tx_start;

    assign transfer = (state == ST_FETCH) && bus.word_valid;

    uart_byte_issuer #(
        .ACCEPT_TIMEOUT(ACCEPT_TIMEOUT)
    ) u_issuer (
        .clk          (clk),
        .reset        (reset),
        .send_req     (send_req),
        .send_byte    (send_byte),
        .send_done    (send_done),
        .send_timeout (send_timeout),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (bus.tx_busy)
    );

    // The word register shifts left after each data byte so the next byte is always the top one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            word_reg    <= '0;
            byte_cnt    <= 2'd0;
            words_sent  <= 8'd0;
            checksum    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && bus.word_valid) begin
                checksum   <= '0;
                words_sent <= 8'd0;
            end
            if (transfer) begin
                word_reg <= bus.word_in;
                byte_cnt <= 2'd0;
                if (words_sent != FRAME_COUNT) begin
                    words_sent <= words_sent + 8'd1;
                end
            end
            if (send_done && (state == ST_COUNT || state == ST_DATA)) begin
                checksum <= checksum + send_byte;
            end
            if (send_done && state == ST_DATA) begin
                word_reg <= word_reg << 8;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (send_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        send_req   = 1'b0;
        send_byte  = 8'h00;
        case (state)
            ST_IDLE: begin
                if (bus.word_valid) begin
                    state_next = ST_HEADER;
                end
            end
            ST_HEADER: begin
                send_req  = 1'b1;
                send_byte = HEADER_BYTE;
                if (send_done) begin
                    state_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                send_req  = 1'b1;
                send_byte = FRAME_COUNT;
                if (send_done) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (transfer) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                send_req  = 1'b1;
                send_byte = word_reg[WORD_WIDTH-1 -: 8];
                if (send_done && byte_cnt == LAST_BYTE) begin
                    state_next = (words_sent < FRAME_COUNT) ? ST_FETCH : ST_CHECKSUM;
                end
            end
            ST_CHECKSUM: begin
                send_req  = 1'b1;
                send_byte = checksum;
                if (send_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // A byte the core never accepted abandons the whole frame.
        if (send_timeout) begin
            state_next = ST_IDLE;
        end
    end

    assign bus.word_ready   = (state == ST_FETCH);
    assign bus.tx_data      = tx_data;
    assign bus.tx_start     = tx_start;
    assign bus.frame_active = (state != ST_IDLE);
    assign bus.timeout_err  = timeout_err;

endmodule
